// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Round-robin arbiter sharing one multi-cycle ALU between two
//             requesters; one operation in flight, response held until taken.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req0_valid,
    input  logic [4:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [63:0] alu_out,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [63:0] rsp_data,
    output logic        rsp_dz,
    input  logic        rsp_ready,
    output logic        busy
);

    localparam logic [4:0] c_OP_MUL  = 5'b01100;
    localparam logic [4:0] c_OP_DIV  = 5'b01101;
    localparam logic [3:0] c_MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] c_DIV_CNT = 4'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_grant;
    logic        r_id;
    logic [4:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_cnt;
    logic [63:0] r_rsp_data;
    logic        r_rsp_dz;

    logic        w_idle;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_accept;
    logic [4:0]  w_sel_op;
    logic [31:0] w_sel_a;
    logic [31:0] w_sel_b;
    logic        w_dz;
    logic [3:0]  w_cnt_load;

    // last_grant == 1 means port 1 was served last, so port 0 wins a tie.
    always_comb begin
        w_idle   = (r_state == ST_IDLE);
        w_gnt0   = w_idle && req0_valid && (!req1_valid || r_last_grant);
        w_gnt1   = w_idle && req1_valid && (!req0_valid || !r_last_grant);
        w_accept = w_gnt0 || w_gnt1;
        w_sel_op = w_gnt1 ? req1_op : req0_op;
        w_sel_a  = w_gnt1 ? req1_a  : req0_a;
        w_sel_b  = w_gnt1 ? req1_b  : req0_b;
        w_dz     = (w_sel_op == c_OP_DIV) && (w_sel_b == 32'd0);
    end

    always_comb begin
        w_cnt_load = 4'd0;
        if (!w_dz) begin
            case (w_sel_op)
                c_OP_MUL: w_cnt_load = c_MUL_CNT;
                c_OP_DIV: w_cnt_load = c_DIV_CNT;
                default:  w_cnt_load = 4'd0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)         w_state_nxt = w_dz ? ST_RESP : ST_EXEC;
            ST_EXEC: if (r_cnt == 4'd0)    w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready)        w_state_nxt = ST_IDLE;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_op         <= 5'd0;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_cnt        <= 4'd0;
            r_rsp_data   <= 64'd0;
            r_rsp_dz     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_id         <= w_gnt1;
                r_last_grant <= w_gnt1;
                r_op         <= w_sel_op;
                r_a          <= w_sel_a;
                r_b          <= w_sel_b;
                r_cnt        <= w_cnt_load;
                // Divide by zero never reaches the ALU: response is known now.
                if (w_dz) begin
                    r_rsp_data <= 64'd0;
                    r_rsp_dz   <= 1'b1;
                end
            end else if (r_state == ST_EXEC) begin
                if (r_cnt == 4'd0) begin
                    r_rsp_data <= alu_out;
                    r_rsp_dz   <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

    always_comb begin
        req0_ready = w_gnt0;
        req1_ready = w_gnt1;
        alu_op     = (r_state == ST_EXEC) ? r_op : 5'd0;
        alu_a      = (r_state == ST_EXEC) ? r_a  : 32'd0;
        alu_b      = (r_state == ST_EXEC) ? r_b  : 32'd0;
        rsp_valid  = (r_state == ST_RESP);
        rsp_id     = rsp_valid && r_id;
        rsp_data   = rsp_valid ? r_rsp_data : 64'd0;
        rsp_dz     = rsp_valid && r_rsp_dz;
        busy       = !w_idle;
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Self-checking bench for alu_arbiter with a transaction-level
//             reference model and directed scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;
    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00011;
    localparam logic [4:0] OP_MUL = 5'b01100;
    localparam logic [4:0] OP_DIV = 5'b01101;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [4:0]  req0_op, req1_op, alu_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
    logic [63:0] alu_out, rsp_data;
    logic        rsp_valid, rsp_id, rsp_dz, rsp_ready, busy;

    always #5 clk = ~clk;

    alu_arbiter #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .clr(clr),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_dz(rsp_dz),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    // Shared ALU environment
    function automatic logic [63:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return {32'd0, a} + {32'd0, b};
            OP_AND:  return {32'd0, a & b};
            OP_MUL:  return {32'd0, a} * {32'd0, b};
            OP_DIV:  return (b == 32'd0) ? 64'd0 : {a % b, a / b};
            default: return 64'd0;
        endcase
    endfunction

    function automatic int lat_of(input logic [4:0] op);
        if (op == OP_MUL) return MUL_LAT;
        if (op == OP_DIV) return DIV_LAT;
        return 1;
    endfunction

    always_comb alu_out = alu_f(alu_op, alu_a, alu_b);

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: one transaction with an accept cycle and a due cycle.
    logic        m_busy, m_last, m_id, m_dz;
    logic [4:0]  m_op;
    logic [31:0] m_a, m_b;
    logic [63:0] m_res;
    int          m_due;
    logic        e_win0, e_win1, n_dz, e_exec, e_resp;
    logic [4:0]  n_op;
    logic [31:0] n_a, n_b;

    always_comb begin
        e_win0 = !m_busy && req0_valid && (!req1_valid || m_last);
        e_win1 = !m_busy && req1_valid && (!req0_valid || !m_last);
        n_op   = e_win1 ? req1_op : req0_op;
        n_a    = e_win1 ? req1_a  : req0_a;
        n_b    = e_win1 ? req1_b  : req0_b;
        n_dz   = (n_op == OP_DIV) && (n_b == 32'd0);
        e_exec = m_busy && (cyc < m_due);
        e_resp = m_busy && (cyc >= m_due);
    end

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_busy <= 1'b0;
            m_last <= 1'b1;
            m_due  <= 0;
        end else if (!m_busy) begin
            if (e_win0 || e_win1) begin
                m_busy <= 1'b1;
                m_id   <= e_win1;
                m_last <= e_win1;
                m_op   <= n_op;
                m_a    <= n_a;
                m_b    <= n_b;
                m_dz   <= n_dz;
                m_res  <= n_dz ? 64'd0 : alu_f(n_op, n_a, n_b);
                m_due  <= cyc + 1 + (n_dz ? 0 : lat_of(n_op));
            end
        end else if (cyc >= m_due && rsp_ready) begin
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req0_ready", 64'(req0_ready), 64'(e_win0));
            chk("req1_ready", 64'(req1_ready), 64'(e_win1));
            chk("alu_op",     64'(alu_op),     e_exec ? 64'(m_op) : 64'd0);
            chk("alu_a",      64'(alu_a),      e_exec ? 64'(m_a)  : 64'd0);
            chk("alu_b",      64'(alu_b),      e_exec ? 64'(m_b)  : 64'd0);
            chk("rsp_valid",  64'(rsp_valid),  64'(e_resp));
            chk("rsp_id",     64'(rsp_id),     e_resp ? 64'(m_id) : 64'd0);
            chk("rsp_data",   rsp_data,        e_resp ? m_res     : 64'd0);
            chk("rsp_dz",     64'(rsp_dz),     e_resp ? 64'(m_dz) : 64'd0);
            chk("busy",       64'(busy),       64'(m_busy));
        end
    end

    // Requester queues, accept and response logs
    logic [68:0] q0[$];
    logic [68:0] q1[$];
    logic        acc0 = 1'b0, acc1 = 1'b0;
    int          acc_cyc[2];
    int          grant_log[$];
    logic [64:0] rsp_log[$];
    int          rsp_done_cyc = 0;

    always @(negedge clk) begin
        acc0 <= req0_valid && req0_ready && !clr;
        acc1 <= req1_valid && req1_ready && !clr;
        if (req0_valid && req0_ready && !clr) begin
            acc_cyc[0] <= cyc;
            grant_log.push_back(0);
        end
        if (req1_valid && req1_ready && !clr) begin
            acc_cyc[1] <= cyc;
            grant_log.push_back(1);
        end
        if (rsp_valid && rsp_ready && !clr) begin
            rsp_log.push_back({rsp_id, rsp_data});
            rsp_done_cyc <= cyc;
        end
    end

    initial begin
        req0_valid = 1'b0; req0_op = 5'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_valid = 1'b0; req1_op = 5'd0; req1_a = 32'd0; req1_b = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (clr) begin
                q0.delete();
                q1.delete();
            end else begin
                if (acc0 && q0.size() > 0) void'(q0.pop_front());
                if (acc1 && q1.size() > 0) void'(q1.pop_front());
            end
            if (q0.size() > 0) begin
                req0_valid = 1'b1;
                {req0_op, req0_a, req0_b} = q0[0];
            end else begin
                req0_valid = 1'b0; req0_op = 5'd0; req0_a = 32'd0; req0_b = 32'd0;
            end
            if (q1.size() > 0) begin
                req1_valid = 1'b1;
                {req1_op, req1_a, req1_b} = q1[0];
            end else begin
                req1_valid = 1'b0; req1_op = 5'd0; req1_a = 32'd0; req1_b = 32'd0;
            end
        end
    end

    task automatic wait_rsp(input int maxc, output int c_first, output int n_exec);
        n_exec  = 0;
        c_first = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                c_first = cyc;
                return;
            end
            if (alu_op != 5'd0) n_exec++;
        end
        chk("rsp_timeout", 64'd0, 64'd1);
    endtask

    int cf, ne, seen;
    int exp_gnt[4] = '{0, 1, 0, 1};
    logic [63:0] exp_dat[4] = '{64'd3, 64'd300, 64'd30, 64'd3000};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rsp_ready = 1'b1;
        #1 clr = 1'b1;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_alu_op",    64'(alu_op),    64'd0);
        @(posedge clk); #1 clr = 1'b0;

        // Port 0 ADD
        @(negedge clk);
        q0.push_back({OP_ADD, 32'd5, 32'd7});
        wait_rsp(20, cf, ne);
        chk("add_latency", 64'(cf - acc_cyc[0]), 64'd2);
        chk("add_data",    rsp_data,             64'd12);
        chk("add_id",      64'(rsp_id),          64'd0);
        chk("add_dz",      64'(rsp_dz),          64'd0);
        repeat (3) @(negedge clk);

        // Port 1 MUL
        q1.push_back({OP_MUL, 32'h0001_0000, 32'h0001_0000});
        wait_rsp(20, cf, ne);
        chk("mul_latency",    64'(cf - acc_cyc[1]), 64'd5);
        chk("mul_exec_cycles", 64'(ne),             64'd4);
        chk("mul_data",       rsp_data,             64'h0000_0001_0000_0000);
        chk("mul_id",         64'(rsp_id),          64'd1);
        repeat (3) @(negedge clk);

        // Port 0 divide by zero
        q0.push_back({OP_DIV, 32'd100, 32'd0});
        wait_rsp(20, cf, ne);
        chk("dz_latency",     64'(cf - acc_cyc[0]), 64'd1);
        chk("dz_exec_cycles", 64'(ne),              64'd0);
        chk("dz_data",        rsp_data,             64'd0);
        chk("dz_flag",        64'(rsp_dz),          64'd1);
        chk("dz_alu_op",      64'(alu_op),          64'd0);
        repeat (3) @(negedge clk);

        // Reset then both ports continuously valid: round robin from port 0
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        grant_log.delete();
        rsp_log.delete();
        @(negedge clk);
        q0.push_back({OP_ADD, 32'd1,    32'd2});
        q0.push_back({OP_ADD, 32'd10,   32'd20});
        q1.push_back({OP_ADD, 32'd100,  32'd200});
        q1.push_back({OP_ADD, 32'd1000, 32'd2000});
        for (int i = 0; i < 200 && rsp_log.size() < 4; i++) @(negedge clk);
        chk("rr_rsp_count",   64'(rsp_log.size()),   64'd4);
        chk("rr_grant_count", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size())
                chk($sformatf("rr_grant%0d", i), 64'(grant_log[i]), 64'(exp_gnt[i]));
            if (i < rsp_log.size()) begin
                chk($sformatf("rr_rsp_id%0d", i),   64'(rsp_log[i][64]), 64'(exp_gnt[i]));
                chk($sformatf("rr_rsp_data%0d", i), rsp_log[i][63:0],    exp_dat[i]);
            end
        end
        repeat (3) @(negedge clk);

        // Response stall with a waiting port 1 request
        rsp_ready = 1'b0;
        q0.push_back({OP_DIV, 32'd100, 32'd7});
        repeat (3) @(negedge clk);
        q1.push_back({OP_ADD, 32'd3, 32'd4});
        wait_rsp(40, cf, ne);
        chk("stall_latency", 64'(cf - acc_cyc[0]), 64'(DIV_LAT + 1));
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("stall_valid%0d", i),  64'(rsp_valid),  64'd1);
            chk($sformatf("stall_data%0d", i),   rsp_data,        64'h0000_0002_0000_000E);
            chk($sformatf("stall_dz%0d", i),     64'(rsp_dz),     64'd0);
            chk($sformatf("stall_req1_rdy%0d", i), 64'(req1_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        wait_rsp(20, cf, ne);
        chk("stall_p1_accept", 64'(acc_cyc[1]), 64'(rsp_done_cyc + 1));
        chk("stall_p1_data",   rsp_data,        64'd7);
        chk("stall_p1_id",     64'(rsp_id),     64'd1);
        repeat (3) @(negedge clk);

        // Reset in the middle of a divide
        q0.push_back({OP_DIV, 32'd100, 32'd7});
        for (int i = 0; i < 20 && alu_op != OP_DIV; i++) @(negedge clk);
        chk("abort_in_exec", 64'(alu_op), 64'(OP_DIV));
        repeat (2) @(negedge clk);
        @(posedge clk); #1 clr = 1'b1;
        #1;
        chk("abort_busy",      64'(busy),      64'd0);
        chk("abort_alu_op",    64'(alu_op),    64'd0);
        chk("abort_alu_a",     64'(alu_a),     64'd0);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 clr = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("abort_no_rsp", 64'(seen), 64'd0);
        q0.push_back({OP_AND, 32'h0000_F0F0, 32'h0000_FF00});
        wait_rsp(20, cf, ne);
        chk("and_latency", 64'(cf - acc_cyc[0]), 64'd2);
        chk("and_data",    rsp_data,             64'h0000_0000_0000_F000);
        chk("and_id",      64'(rsp_id),          64'd0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
